// File: rtl/mem_stage_pkg.sv
// Shared defines for the memory-access stage.
// Opcodes, bus constants and the FSM state encoding.
package mem_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
    localparam logic                  RstEnable    = 1'b1;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;

    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LB_OP)  || (op == EXE_LH_OP)  ||
               (op == EXE_LW_OP)  || (op == EXE_LBU_OP) ||
               (op == EXE_LHU_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) ||
               (op == EXE_SW_OP);
    endfunction

    function automatic logic is_half(input logic [7:0] op);
        return (op == EXE_LH_OP) || (op == EXE_LHU_OP) ||
               (op == EXE_SH_OP);
    endfunction

    function automatic logic is_word(input logic [7:0] op);
        return (op == EXE_LW_OP) || (op == EXE_SW_OP);
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment.
    function automatic logic is_misaligned(input logic [7:0] op,
                                           input logic [1:0] off);
        return (is_half(op) && off[0]) ||
               (is_word(op) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane steering for stores and
// lane extraction plus extension for loads.
module mem_lane_fmt
    import mem_stage_pkg::*;
(
    input  logic [7:0]        op,
    input  logic [1:0]        off,
    input  logic [RegBus-1:0] reg2,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] ldata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/half; offset 0 is the most significant lane.
    always_comb begin
        byte_v = rdata[31:24];
        unique case (off)
            2'd0: byte_v = rdata[31:24];
            2'd1: byte_v = rdata[23:16];
            2'd2: byte_v = rdata[15:8];
            2'd3: byte_v = rdata[7:0];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[15:0] : rdata[31:16];
    end

    // Lane selects, replicated store data and extended load data.
    always_comb begin
        sel   = 4'b0000;
        wdata = ZeroWord;
        ldata = ZeroWord;
        unique case (1'b1)
            is_word(op): begin
                sel   = 4'b1111;
                wdata = reg2;
            end
            is_half(op): begin
                sel   = off[1] ? 4'b0011 : 4'b1100;
                wdata = {2{reg2[15:0]}};
            end
            default: begin
                sel   = 4'b1000 >> off;
                wdata = {4{reg2[7:0]}};
            end
        endcase
        unique case (1'b1)
            (op == EXE_LB_OP):  ldata = {{24{byte_v[7]}}, byte_v};
            (op == EXE_LBU_OP): ldata = {24'h0, byte_v};
            (op == EXE_LH_OP):  ldata = {{16{half_v[15]}}, half_v};
            (op == EXE_LHU_OP): ldata = {16'h0, half_v};
            (op == EXE_LW_OP):  ldata = rdata;
            default:            ldata = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: single-outstanding
// request/ack bus master with load formatting and stall.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [7:0]            ex_aluop,
    input  logic [RegBus-1:0]     ex_mem_addr,
    input  logic [RegBus-1:0]     ex_reg2,
    input  logic                  flush,
    input  logic [RegBus-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [RegBus-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [RegBus-1:0]     bus_wdata,
    output logic [RegAddrBus-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [RegBus-1:0]     mem_wdata,
    output logic                  stallreq,
    output logic                  exc_misalign,
    output logic                  bus_err
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(BUS_TIMEOUT);

    mem_state_e        state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [RegBus-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [RegBus-1:0] bus_wdata_q, bus_wdata_d;
    logic [RegBus-1:0] ldata_q, ldata_d;
    logic              err_q, err_d;
    logic              flushed_q, flushed_d;

    logic              op_ld, op_st, op_mem, misal, go;
    logic [3:0]        sel_c;
    logic [RegBus-1:0] wdata_c, ldata_c;

    mem_lane_fmt u_fmt (
        .op    (ex_aluop),
        .off   (ex_mem_addr[1:0]),
        .reg2  (ex_reg2),
        .rdata (bus_rdata),
        .sel   (sel_c),
        .wdata (wdata_c),
        .ldata (ldata_c)
    );

    assign op_ld   = is_load(ex_aluop);
    assign op_st   = is_store(ex_aluop);
    assign op_mem  = op_ld | op_st;
    assign misal   = op_mem & is_misaligned(ex_aluop, ex_mem_addr[1:0]);
    assign go      = op_mem & ~misal & ~flush;
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state: issue, wait for ack or timeout, one DONE cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        ldata_d     = ldata_q;
        err_d       = err_q;
        flushed_d   = flushed_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = op_st;
                    bus_addr_d  = {ex_mem_addr[31:2], 2'b00};
                    bus_sel_d   = sel_c;
                    bus_wdata_d = wdata_c;
                    err_d       = 1'b0;
                    flushed_d   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (bus_ack) begin
                    ldata_d   = ldata_c;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIM) begin
                        bus_req_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= ZeroWord;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= ZeroWord;
            ldata_q     <= ZeroWord;
            err_q       <= 1'b0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            ldata_q     <= ldata_d;
            err_q       <= err_d;
            flushed_q   <= flushed_d;
        end
    end

    // Write-back triple, stall and one-cycle exception flags.
    always_comb begin
        mem_wd       = NOPRegAddr;
        mem_wreg     = WriteDisable;
        mem_wdata    = ZeroWord;
        stallreq     = 1'b0;
        exc_misalign = 1'b0;
        bus_err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!op_mem) begin
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg;
                    mem_wdata = ex_wdata;
                end else if (misal) begin
                    exc_misalign = 1'b1;
                end else if (!flush) begin
                    stallreq = 1'b1;
                end
            end
            ST_BUSY: begin
                stallreq = 1'b1;
            end
            ST_DONE: begin
                if (op_ld && !err_q && !flushed_q) begin
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg ? WriteEnable : WriteDisable;
                    mem_wdata = ldata_q;
                end
                bus_err = err_q & ~flushed_q;
            end
            default: begin
                stallreq = 1'b0;
            end
        endcase
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a
// transaction-level model of the memory stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int BUS_TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic        flush;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq;
    logic        exc_misalign;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.BUS_TIMEOUT(BUS_TO), .TO_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .flush        (flush),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_sel      (bus_sel),
        .bus_wdata    (bus_wdata),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .stallreq     (stallreq),
        .exc_misalign (exc_misalign),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; 0 for non-memory ops.
    function automatic int m_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
            EXE_LW_OP, EXE_SW_OP:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit m_is_ld(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP,
                          EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input int o);
        int s = m_size(op);
        if (s == 4) return 4'b1111;
        if (s == 2) return (o == 0) ? 4'b1100 : 4'b0011;
        return 4'(8 >> o);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op,
                                            input logic [31:0] d);
        int s = m_size(op);
        if (s == 4) return d;
        if (s == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return (d & 32'hFF) * 32'h0101_0101;
    endfunction

    // Byte at offset o lives (3-o) bytes above bit 0.
    function automatic logic [31:0] m_load(input logic [7:0] op, input int o,
                                           input logic [31:0] r);
        logic [31:0] v;
        int s = m_size(op);
        if (s == 4) return r;
        if (s == 2) begin
            v = (r >> (8 * (2 - o))) & 32'hFFFF;
            if (op == EXE_LH_OP && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = (r >> (8 * (3 - o))) & 32'hFF;
            if (op == EXE_LB_OP && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    task automatic run_alu(input logic [7:0] op, input logic [4:0] wd,
                           input logic wreg, input logic [31:0] wdata);
        ex_aluop = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_mem_addr = $urandom; ex_reg2 = $urandom;
        flush = 1'b0; bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("alu mem_wd", mem_wd, wd);
        chk("alu mem_wreg", mem_wreg, wreg);
        chk("alu mem_wdata", mem_wdata, wdata);
        chk("alu stallreq", stallreq, 0);
        chk("alu bus_req", bus_req, 0);
        chk("alu misalign", exc_misalign, 0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
    endtask

    // One memory transaction; ack_dly >= BUS_TO means no ack ever.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [31:0] rdata,
                           input logic [4:0] wd, input logic wreg,
                           input int ack_dly, input int flush_at);
        bit mis, to, fl, ld;
        int o, last, stalls;
        o  = int'(addr[1:0]);
        ld = m_is_ld(op);
        mis = (m_size(op) == 2 && (o % 2) != 0) ||
              (m_size(op) == 4 && o != 0);
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
        ex_wd = wd; ex_wreg = wreg; ex_wdata = $urandom;
        flush = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
        @(negedge clk);
        chk("idle bus_req", bus_req, 0);
        chk("idle misalign", exc_misalign, 32'(mis));
        if (mis) begin
            chk("mis stallreq", stallreq, 0);
            chk("mis mem_wreg", mem_wreg, 0);
            @(posedge clk); #1;
            ex_aluop = 8'h00;
            @(negedge clk);
            chk("mis no bus_req", bus_req, 0);
            @(posedge clk); #1;
            return;
        end
        stalls = stallreq ? 1 : 0;
        @(posedge clk); #1;
        to   = ack_dly >= BUS_TO;
        last = to ? BUS_TO - 1 : ack_dly;
        fl   = flush_at >= 0 && flush_at <= last;
        for (int i = 0; i <= last; i++) begin
            bus_ack   = (i == ack_dly);
            flush     = (i == flush_at);
            bus_rdata = bus_ack ? rdata : $urandom;
            @(negedge clk);
            chk("busy bus_req", bus_req, 1);
            if (stallreq) stalls++;
            if (i == 0) begin
                chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                chk("bus_sel", bus_sel, m_sel(op, o));
                chk("bus_we", bus_we, 32'(!ld));
                if (!ld) chk("bus_wdata", bus_wdata, m_wdata(op, reg2));
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        bus_rdata = $urandom;
        bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (stallreq) stalls++;
        chk("done stallreq", stallreq, 0);
        chk("stall cycles", stalls, last + 2);
        chk("done bus_req", bus_req, 0);
        chk("done mem_wreg", mem_wreg, 32'(ld && !to && !fl && wreg));
        if (ld && !to && !fl) begin
            chk("done mem_wd", mem_wd, wd);
            chk("done mem_wdata", mem_wdata, m_load(op, o, rdata));
        end
        chk("done bus_err", bus_err, 32'(to && !fl));
        @(posedge clk); #1;
        bus_ack = 1'b0;
    endtask

    logic [7:0] mem_ops [8];
    logic [7:0] rop;

    initial begin
        mem_ops = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP,
                    EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        rst = 1'b1; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0;
        ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
        flush = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst bus_req", bus_req, 0);
        chk("rst bus_we", bus_we, 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_sel", bus_sel, 0);
        chk("rst bus_wdata", bus_wdata, 0);
        chk("rst mem_wreg", mem_wreg, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst stallreq", stallreq, 0);
        chk("rst bus_err", bus_err, 0);
        @(posedge clk); #1;

        run_alu(8'h25, 5'd3, 1'b1, 32'h55);
        run_mem(EXE_LW_OP, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 1'b1, 0, -1);
        run_mem(EXE_LB_OP, 32'h103, 32'h0, 32'h123456F0, 5'd8, 1'b1, 0, -1);
        run_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h123456F0, 5'd9, 1'b1, 0, -1);
        run_mem(EXE_LH_OP, 32'h102, 32'h0, 32'h00008001, 5'd10, 1'b1, 0, -1);
        run_mem(EXE_SH_OP, 32'h206, 32'hAAAA1234, 32'h0, 5'd0, 1'b1, 3, -1);
        run_mem(EXE_LW_OP, 32'h101, 32'h0, 32'h0, 5'd4, 1'b1, 0, -1);
        run_mem(EXE_LW_OP, 32'h300, 32'h0, 32'h0, 5'd5, 1'b1, 9, -1);
        run_mem(EXE_LW_OP, 32'h304, 32'h0, 32'h11112222, 5'd6, 1'b1, 3, 1);
        run_mem(EXE_LHU_OP, 32'h30A, 32'h0, 32'h8765ABCD, 5'd6, 1'b1, 2, 2);

        // Flush in IDLE: no request may be issued.
        ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h400; flush = 1'b1;
        @(negedge clk);
        chk("flush idle stallreq", stallreq, 0);
        @(posedge clk); #1;
        flush = 1'b0; ex_aluop = 8'h00;
        @(negedge clk);
        chk("flush idle bus_req", bus_req, 0);
        @(posedge clk); #1;

        // Reset during BUSY, then a late ack in IDLE.
        ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h500; ex_wreg = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre-rst bus_req", bus_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ex_aluop = 8'h00;
        @(negedge clk);
        chk("post-rst bus_req", bus_req, 0);
        chk("post-rst stallreq", stallreq, 0);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late ack bus_req", bus_req, 0);
        chk("late ack stallreq", stallreq, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do rop = 8'($urandom); while (m_size(rop) != 0);
                run_alu(rop, 5'($urandom), 1'($urandom), $urandom);
            end else begin
                run_mem(mem_ops[$urandom_range(0, 7)], $urandom, $urandom,
                        $urandom, 5'($urandom), 1'($urandom),
                        $urandom_range(0, 5),
                        ($urandom_range(0, 4) == 0) ?
                            int'($urandom_range(0, 3)) : -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, between the ex_mem register and the mem_wb register.
- Executes loads and stores over a single-outstanding request/ack data bus, which is big-endian and word-addressed with byte selects.
- Formats load data (byte/half extraction, sign/zero extension) and produces the write-back triple (mem_wd, mem_wreg, mem_wdata).
- Holds the pipeline through stallreq while a bus access is pending.

Parameters:
- BUS_TIMEOUT, 255: max cycles in BUSY without bus_ack before the access is aborted with error.
- TO_W, 8: width of the timeout counter; must satisfy 2**TO_W > BUS_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_wd  in  5  destination register address
- ex_wreg  in  1  write-enable from EX
- ex_wdata  in  32  ALU result (non-memory ops)
- ex_aluop  in  8  operation code
- ex_mem_addr  in  32  effective byte address
- ex_reg2  in  32  store data
- flush  in  1  pipeline flush from ctrl
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  single-cycle transfer complete
- bus_req  out  1  request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  word address (low 2 bits forced 0)
- bus_sel  out  4  byte lanes, bit3 = bits[31:24]
- bus_wdata  out  32  store data replicated onto lanes
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- stallreq  out  1  stall request to ctrl
- exc_misalign  out  1  one-cycle misaligned-access flag
- bus_err  out  1  one-cycle bus timeout flag

Behaviour:
- Reset: state IDLE, timeout counter 0, bus_req/bus_we 0, bus_addr/bus_wdata 0, bus_sel 0, load-data register 0.
- Combinational outputs follow from state=IDLE with no memory op: mem_wd=0, mem_wreg=0, mem_wdata=0, stallreq=0, exc_misalign=0, bus_err=0.
- The ex_* inputs are guaranteed stable while stallreq=1.
- Opcode classes:
  - Loads: LB, LBU, LH, LHU, LW.
  - Stores: SB, SH, SW.
  - Anything else is non-memory.
- Non-memory op: combinational pass-through (mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata=ex_wdata, stallreq=0). Zero added latency. No bus activity.
- Alignment:
  - Halfword ops require addr[0]=0; word ops require addr[1:0]=0.
  - On misalignment in IDLE: exc_misalign=1 the same cycle, mem_wreg=0, stallreq=0, no bus request, state stays IDLE.
- Byte lanes (big-endian):
  - Byte: offset 0..3 -> sel 1000, 0100, 0010, 0001; bus_wdata = {4{ex_reg2[7:0]}}.
  - Half: offset 0 -> 1100, offset 2 -> 0011; bus_wdata = {2{ex_reg2[15:0]}}.
  - Word: sel 1111; bus_wdata = ex_reg2.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with aligned memory op and flush=0: stallreq=1 combinationally. Next edge: BUSY, with bus_req=1 and bus_we/bus_addr/bus_sel/bus_wdata registered, counter cleared.
  - BUSY: stallreq=1; counter increments each cycle with bus_ack=0.
  - BUSY, bus_ack=1: capture the formatted bus_rdata, drop bus_req, go to DONE.
  - BUSY, counter reaches BUS_TIMEOUT with no ack: drop bus_req, set error flag, go to DONE.
  - DONE: stallreq=0.
    - Load: mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata=captured data.
    - Store: mem_wreg=0.
    - Error: mem_wreg=0 and bus_err=1.
    - Next edge: IDLE.
- Latency: with ack in the first BUSY cycle, a load occupies 3 cycles (IDLE, BUSY, DONE), so stallreq is high for 2 cycles.
- Load formatting: LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged. Lane selection uses ex_mem_addr[1:0].
- Flush:
  - In IDLE: no request is issued.
  - In BUSY: the bus transaction still completes (bus_req held until ack or timeout). A sticky flushed bit then suppresses DONE write-back (mem_wreg=0, bus_err=0).
  - If flush and ack arrive together, the write-back is still suppressed.
- Reset mid-access: bus_req drops at the next edge, state returns to IDLE, and a late ack arriving in IDLE is ignored.
- bus_ack in IDLE or DONE is ignored.

Decomposition:
- Shared defines package holds:
  - Opcodes: EXE_LB_OP 8'hE0, EXE_LH_OP 8'hE1, EXE_LW_OP 8'hE3, EXE_LBU_OP 8'hE4, EXE_LHU_OP 8'hE5, EXE_SB_OP 8'hE8, EXE_SH_OP 8'hE9, EXE_SW_OP 8'hEB.
  - Constants: RegBus, RegAddrBus, ZeroWord, NOPRegAddr, RstEnable, WriteEnable/WriteDisable.
  - FSM state encodings.
- One natural sub-module, mem_lane_fmt (combinational): computes bus_sel/bus_wdata from op and address, and formats the loaded data from op, address and rdata.

Test Plan:
- LW at addr 0x100, bus_rdata 0xDEADBEEF with ack in the first BUSY cycle -> bus_addr=0x100, sel=1111; stallreq high 2 cycles; DONE: mem_wdata=0xDEADBEEF, mem_wreg=1, mem_wd=ex_wd.
- LB at addr 0x103, rdata 0x123456F0 -> sel=0001, mem_wdata=0xFFFFFFF0. Same with LBU -> 0x000000F0. LH at 0x102, rdata 0x0000_8001 -> 0xFFFF8001.
- SH at 0x206, ex_reg2 0xAAAA1234, ack after 3 wait cycles -> bus_we=1, sel=0011, bus_wdata=0x12341234; stallreq high 5 cycles; mem_wreg=0 in DONE.
- LW at 0x101 -> exc_misalign=1 the same cycle, bus_req never asserted, stallreq=0, mem_wreg=0.
- LW with no ack, BUS_TIMEOUT=4 -> bus_req high 4 cycles then low; bus_err=1 for one cycle; mem_wreg=0; back to IDLE. A flush asserted mid-BUSY, with ack later -> write-back suppressed. rst asserted mid-BUSY -> bus_req=0 next cycle.
- Non-memory op (aluop 8'h25), ex_wdata 0x55 -> same-cycle pass-through, stallreq=0, no bus activity.
